xilly_stream_fifo: RTL



---
 rtl/xilly_fifo_pkg.sv | 24 ++
 rtl/xilly_sdp_ram.sv | 40 ++++
 rtl/xilly_stream_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/xilly_fifo_pkg.sv
// xilly_fifo_pkg: shared constants and helpers for the Xillybus stream FIFO.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter.
//   clog2()              : ceiling log2 used for address widths.
//   level_w()            : width of the fill-level output (one extra bit so
//                          that a completely full FIFO is representable).
package xilly_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int level_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/xilly_sdp_ram.sv
// xilly_sdp_ram: simple dual-port inferred RAM, WIDTH x 2**AW words.
//   clk   : single clock
//   clr   : synchronous clear of the read output register only
//   we    : write enable; waddr/wdata give the write location and word
//   re    : read enable; rdata is registered and holds while re is low
//   raddr : read address
// A read and a write to the same address on one edge return the old word,
// which the FIFO relies on when it is full and both ports move together.
module xilly_sdp_ram
  import xilly_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // stage boundary: registered read port
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/xilly_stream_fifo.sv
// xilly_stream_fifo: single-clock stream FIFO between Xillybus streams.
//   bus_clk, srst_n          : clock, synchronous active-low reset
//   user_w_wren/data/full    : write side; writes ignored while full unless
//                              a read is accepted in the same cycle
//   user_w_open, user_r_open : device-file open flags; both low flushes
//   user_r_rden/data/empty   : read side (standard or FWFT, see FWFT)
//   user_r_eof               : writer closed and everything drained
//   level                    : words held, including the FWFT output stage
//   overflow, underflow      : sticky misuse flags
module xilly_stream_fifo
  import xilly_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int FWFT       = FIFO_STD,
  parameter int EOF_EN     = 1
) (
  input  logic                               bus_clk,
  input  logic                               srst_n,
  input  logic                               user_w_wren,
  input  logic [WIDTH-1:0]                   user_w_data,
  output logic                               user_w_full,
  input  logic                               user_w_open,
  input  logic                               user_r_rden,
  output logic [WIDTH-1:0]                   user_r_data,
  output logic                               user_r_empty,
  output logic                               user_r_eof,
  input  logic                               user_r_open,
  output logic [level_w(DEPTH_LOG2)-1:0]     level,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = clog2(DEPTH);
  localparam int LW    = level_w(DEPTH_LOG2);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE      = LW'(1);

  logic          clr;
  logic          wr_acc;
  logic          rd_acc;
  logic          ram_we;
  logic          rd_en_p0;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] ram_cnt;
  logic [LW-1:0] ram_cnt_nxt;
  logic [LW-1:0] level_nxt;
  logic          vld_p1;
  logic          vld_p1_nxt;
  logic          empty_nxt;
  logic          w_open_d;
  logic          w_closed;

  // Flush behaves exactly like reset and wins over any strobe.
  assign clr    = !srst_n || (!user_w_open && !user_r_open);
  assign rd_acc = user_r_rden && !user_r_empty;
  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign wr_acc = user_w_wren && (!user_w_full || rd_acc);
  assign ram_we = wr_acc && !clr;

  // stage p0: RAM read issue. In FWFT mode the RAM output register is the
  // output stage; it is refilled whenever it is empty or being consumed.
  always_comb begin
    rd_en_p0   = rd_acc;
    vld_p1_nxt = 1'b0;
    if (FWFT == FIFO_FWFT) begin
      rd_en_p0 = (ram_cnt != '0) && (!vld_p1 || rd_acc);
      if (rd_en_p0)    vld_p1_nxt = 1'b1;
      else if (rd_acc) vld_p1_nxt = 1'b0;
      else             vld_p1_nxt = vld_p1;
    end
    ram_cnt_nxt = ram_cnt;
    if (wr_acc)   ram_cnt_nxt = ram_cnt_nxt + ONE;
    if (rd_en_p0) ram_cnt_nxt = ram_cnt_nxt - ONE;
    level_nxt = ram_cnt_nxt + {{(LW-1){1'b0}}, vld_p1_nxt};
    empty_nxt = (FWFT == FIFO_FWFT) ? !vld_p1_nxt : (ram_cnt_nxt == '0);
  end

  xilly_sdp_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (bus_clk),
    .clr   (clr),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (user_w_data),
    .re    (rd_en_p0),
    .raddr (rd_ptr),
    .rdata (user_r_data)
  );

  // stage p1: pointers, count, flags and output-stage valid
  always_ff @(posedge bus_clk) begin
    if (clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ram_cnt      <= '0;
      vld_p1       <= 1'b0;
      level        <= '0;
      user_w_full  <= 1'b0;
      user_r_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      w_closed     <= 1'b0;
      user_r_eof   <= 1'b0;
    end else begin
      if (wr_acc)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_en_p0) rd_ptr <= rd_ptr + 1'b1;
      ram_cnt      <= ram_cnt_nxt;
      vld_p1       <= vld_p1_nxt;
      level        <= level_nxt;
      user_w_full  <= (level_nxt == FULL_LVL);
      user_r_empty <= empty_nxt;
      if (user_w_wren && !wr_acc)      overflow  <= 1'b1;
      if (user_r_rden && user_r_empty) underflow <= 1'b1;
      if (w_open_d && !user_w_open)      w_closed <= 1'b1;
      else if (!w_open_d && user_w_open) w_closed <= 1'b0;
      // level and wr_acc keep EOF low while any word is in flight, which
      // matters in FWFT mode where empty lags the RAM by a cycle.
      user_r_eof <= (EOF_EN != 0) && w_closed && user_r_empty && user_r_open &&
                    (level == '0) && !wr_acc;
    end
  end

  // Open-edge tracker runs through reset so no false edge follows it.
  always_ff @(posedge bus_clk) begin
    w_open_d <= user_w_open;
  end

endmodule
